// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// Holds one outstanding request; the ack is a single-cycle strobe.
interface inst_fetch_unit_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;

   modport master (output im_req, output im_addr, input im_ack, input im_rdata);
   modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues word fetches and buffers one instruction for IF/ID.
// Redirects inject a NOP into IF/ID and steer the next fetch to the new target.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      rst,
   inst_fetch_unit_if.master         im,
   input  logic                      pc_write,
   input  logic                      redirect,
   input  logic [31:0]               redirect_pc,
   output logic [31:0]               pc_out,
   output logic [31:0]               inst,
   output logic                      ifid_write
);

   typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic [31:0] target;

   assign target = redirect_pc & ~32'h3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         buf_pc_q   <= '0;
         buf_inst_q <= '0;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         buf_pc_q   <= buf_pc_d;
         buf_inst_q <= buf_inst_d;
         out_addr_q <= out_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_pc_d    = buf_pc_q;
      buf_inst_d  = buf_inst_q;
      out_addr_d  = out_addr_q;
      im.im_req   = 1'b0;
      im.im_addr  = pc_q;
      ifid_write  = 1'b0;
      pc_out      = buf_pc_q;
      inst        = buf_inst_q;

      case (state_q)
         FETCH: begin
            im.im_req  = 1'b1;
            im.im_addr = pc_q;
            if (redirect) begin
               pc_d = target;
               // A request still in flight must be drained before the new one issues.
               if (!im.im_ack) begin
                  state_d    = DROP;
                  out_addr_d = pc_q;
               end
            end else if (im.im_ack) begin
               buf_pc_d   = pc_q;
               buf_inst_d = im.im_rdata;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (pc_write) begin
               ifid_write = 1'b1;
               pc_d       = buf_pc_q + 32'd4;
               state_d    = FETCH;
            end
         end
         DROP: begin
            im.im_req  = 1'b1;
            im.im_addr = out_addr_q;
            if (redirect) pc_d = target;
            if (im.im_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      // Redirect overrides stall and buffered data alike.
      if (redirect) begin
         ifid_write = 1'b1;
         inst       = NOP_INST;
         pc_out     = target;
      end

      if (rst) begin
         im.im_req  = 1'b0;
         ifid_write = 1'b0;
         pc_out     = '0;
         inst       = '0;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: stimulus pushes expected IF/ID writes and
// signal probes into queues; a negedge monitor pops and compares them.
module tb_inst_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int S_REQ = 0, S_ADDR = 1, S_WR = 2, S_PC = 3, S_INST = 4, S_SBQ = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] pc_out;
   logic [31:0] inst;
   logic        ifid_write;

   inst_fetch_unit_if bus();

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .im(bus.master),
      .pc_write(pc_write), .redirect(redirect), .redirect_pc(redirect_pc),
      .pc_out(pc_out), .inst(inst), .ifid_write(ifid_write)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } wr_t;
   typedef struct { int sig; logic [31:0] exp; string name; } probe_t;

   wr_t    sb[$];
   probe_t pq[$];
   int     total = 0;
   int     bad = 0;

   task automatic step(input logic pw, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      pc_write    = pw;
      redirect    = rd;
      redirect_pc = rpc;
      bus.im_ack  = ack;
      bus.im_rdata = rdata;
   endtask

   task automatic probe(input int sig, input logic [31:0] exp, input string name);
      probe_t p;
      p.sig = sig; p.exp = exp; p.name = name;
      pq.push_back(p);
   endtask

   task automatic expect_wr(input logic [31:0] pc, input logic [31:0] ins);
      wr_t w;
      w.pc = pc; w.inst = ins;
      sb.push_back(w);
   endtask

   // Monitor: sole owner of the counters.
   initial begin : monitor
      wr_t         w;
      probe_t      p;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         if (ifid_write === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL ifid_unexpected: got write pc_out=%h inst=%h, required no write", pc_out, inst);
            end else begin
               w = sb.pop_front();
               if (pc_out !== w.pc || inst !== w.inst) begin
                  bad++;
                  $display("FAIL ifid_write: got pc_out=%h inst=%h, required pc_out=%h inst=%h",
                           pc_out, inst, w.pc, w.inst);
               end
            end
         end
         while (pq.size() != 0) begin
            p = pq.pop_front();
            case (p.sig)
               S_REQ:   act = {31'b0, bus.im_req};
               S_ADDR:  act = bus.im_addr;
               S_WR:    act = {31'b0, ifid_write};
               S_PC:    act = pc_out;
               S_INST:  act = inst;
               default: act = 32'(sb.size());
            endcase
            total++;
            if (act !== p.exp) begin
               bad++;
               $display("FAIL %s: got %h, required %h", p.name, act, p.exp);
            end
         end
      end
   end

   initial begin
      bus.im_ack   = 1'b0;
      bus.im_rdata = '0;

      step(0, 0, 0, 0, 0);
      probe(S_REQ, 0, "rst_req"); probe(S_WR, 0, "rst_wr");
      probe(S_PC, 0, "rst_pc"); probe(S_INST, 0, "rst_inst");

      step(1, 0, 0, 0, 0); rst = 1'b0;
      probe(S_REQ, 1, "first_req"); probe(S_ADDR, 0, "first_addr"); probe(S_WR, 0, "fetch_no_wr");
      step(1, 0, 0, 1, 32'h0050_0093);
      probe(S_ADDR, 0, "first_addr_held");
      step(1, 0, 0, 0, 0); expect_wr(32'h0, 32'h0050_0093);
      probe(S_REQ, 0, "hold_req");
      step(1, 0, 0, 1, 32'h11);
      probe(S_ADDR, 4, "addr_after_first");
      step(1, 0, 0, 0, 0); expect_wr(32'h4, 32'h11);
      step(1, 0, 0, 1, 32'h22);
      probe(S_ADDR, 8, "addr_8");

      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0);
         probe(S_WR, 0, "stall_wr"); probe(S_REQ, 0, "stall_req"); probe(S_PC, 8, "stall_pc");
      end
      step(1, 0, 0, 0, 0); expect_wr(32'h8, 32'h22);
      step(1, 0, 0, 1, 32'h33);
      probe(S_ADDR, 12, "addr_after_stall");

      step(0, 1, 32'h0000_0103, 0, 0); expect_wr(32'h100, NOP);
      probe(S_WR, 1, "redir_hold_wr"); probe(S_INST, NOP, "redir_hold_inst"); probe(S_PC, 32'h100, "redir_hold_pc");
      step(1, 1, 32'h40, 1, 32'hCAFE_0001); expect_wr(32'h40, NOP);
      probe(S_ADDR, 32'h100, "redir_target_addr");
      step(1, 1, 32'h200, 0, 0); expect_wr(32'h200, NOP);
      probe(S_ADDR, 32'h40, "addr_40");
      step(1, 0, 0, 0, 0);
      probe(S_ADDR, 32'h40, "drop_addr_1"); probe(S_REQ, 1, "drop_req"); probe(S_WR, 0, "drop_wr");
      step(1, 0, 0, 0, 0);
      probe(S_ADDR, 32'h40, "drop_addr_2");
      step(1, 0, 0, 1, 32'hDEAD_BEEF);
      probe(S_ADDR, 32'h40, "drop_addr_ack"); probe(S_WR, 0, "drop_ack_wr");
      step(1, 1, 32'h280, 0, 0); expect_wr(32'h280, NOP);
      probe(S_ADDR, 32'h200, "addr_after_drop");
      step(1, 1, 32'h300, 0, 0); expect_wr(32'h300, NOP);
      probe(S_ADDR, 32'h200, "drop2_addr");
      step(1, 1, 32'h30C, 1, 32'hBAD0_BAD0); expect_wr(32'h30C, NOP);
      probe(S_ADDR, 32'h200, "drop2_addr_ack");
      step(1, 0, 0, 1, 32'h44);
      probe(S_ADDR, 32'h30C, "latest_target_addr");

      step(1, 1, 32'hFFFF_FFFE, 0, 0); expect_wr(32'hFFFF_FFFC, NOP);
      step(1, 0, 0, 1, 32'h55);
      probe(S_ADDR, 32'hFFFF_FFFC, "top_addr");
      step(1, 0, 0, 0, 0); expect_wr(32'hFFFF_FFFC, 32'h55);
      step(1, 0, 0, 1, 32'h66);
      probe(S_ADDR, 32'h0, "wrap_addr");
      step(1, 0, 0, 0, 0); expect_wr(32'h0, 32'h66);
      step(1, 0, 0, 0, 0);
      probe(S_ADDR, 32'h4, "pending_addr"); probe(S_REQ, 1, "pending_req");

      step(1, 0, 0, 0, 0); rst = 1'b1;
      probe(S_REQ, 0, "midrst_req"); probe(S_WR, 0, "midrst_wr");
      probe(S_PC, 0, "midrst_pc"); probe(S_INST, 0, "midrst_inst");
      step(1, 0, 0, 0, 0); rst = 1'b0;
      probe(S_REQ, 1, "restart_req"); probe(S_ADDR, 32'h0, "restart_addr");
      step(1, 0, 0, 1, 32'h77);
      step(1, 0, 0, 0, 0); expect_wr(32'h0, 32'h77);
      step(1, 0, 0, 0, 0);
      probe(S_ADDR, 32'h4, "restart_next_addr"); probe(S_SBQ, 0, "sb_drained");

      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction written into the IF/ID register on redirect.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc_write  in  1  hazard-unit enable; 0 = stall, hold the buffered instruction.
REQ-006 redirect  in  1  branch/jump taken; discard the fetch path.
REQ-007 redirect_pc  in  32  new fetch target; bits [1:0] ignored and treated as 0.
REQ-008 im_req  out  1  instruction-memory request.
REQ-009 im_addr  out  32  request address, word aligned.
REQ-010 im_ack  in  1  one-cycle response strobe for the outstanding request.
REQ-011 im_rdata  in  32  instruction word; valid only when im_ack=1.
REQ-012 pc_out  out  32  PC presented to the IF/ID register.
REQ-013 inst  out  32  instruction presented to the IF/ID register.
REQ-014 ifid_write  out  1  IF/ID load enable; IF/ID samples pc_out and inst on the edge ending this cycle.

Function
REQ-015 The unit SHALL hold pc_reg (32), buf_pc (32), buf_inst (32) and a 3-state FSM: FETCH, HOLD, DROP.
REQ-016 Request rule: in FETCH and DROP, im_req SHALL be 1; in HOLD it SHALL be 0.
REQ-017 While im_req=1 and im_ack=0, im_addr SHALL stay stable; a request SHALL never be withdrawn. At most one request SHALL be outstanding.
REQ-018 im_addr SHALL equal pc_reg in FETCH and the outstanding address in DROP.
REQ-019 FETCH with im_ack=1 and redirect=0 SHALL load buf_pc<=pc_reg and buf_inst<=im_rdata, then go to HOLD.
REQ-020 HOLD output rule: pc_out=buf_pc, inst=buf_inst, ifid_write=pc_write & ~redirect (combinational).
REQ-021 HOLD with ifid_write=1 SHALL load pc_reg<=buf_pc+4, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0), then go to FETCH.
REQ-022 HOLD with pc_write=0 and redirect=0 SHALL keep all state unchanged.
REQ-023 Latency: ack in cycle n gives ifid_write=1 no earlier than cycle n+1. Peak throughput is one instruction per 2 cycles.
REQ-024 Redirect output rule: when redirect=1 in any state, ifid_write=1, inst=NOP_INST and pc_out={redirect_pc[31:2],2'b00}, regardless of pc_write. Redirect has priority over stall.
REQ-025 Redirect target: on any redirect, pc_reg SHALL be loaded with {redirect_pc[31:2],2'b00}.
REQ-026 Redirect in HOLD: buffer discarded, go to FETCH.
REQ-027 Redirect in FETCH with im_ack=1: response discarded, stay in FETCH; the new request issues next cycle.
REQ-028 Redirect in FETCH with im_ack=0: go to DROP.
REQ-029 DROP behaviour:
- im_ack=1 with no redirect: response discarded, go to FETCH.
- redirect=1: pc_reg updated, stay in DROP until the ack.
- redirect and ack in the same cycle: pc_reg updated, go to FETCH.
REQ-030 Outside HOLD and with redirect=0, ifid_write SHALL be 0; pc_out and inst then hold their last HOLD values (don't-care to IF/ID).

Reset
REQ-031 While rst=1: state=FETCH, pc_reg=RESET_PC, buf_pc=0, buf_inst=0, im_req=0, ifid_write=0, pc_out=0, inst=0.
REQ-032 Reset SHALL abandon any outstanding request. The memory model SHALL drop any ack pending across reset.
REQ-033 The first cycle after rst falls SHALL assert im_req=1 with im_addr=RESET_PC.

Verification
REQ-034 Reset release, ack after 1 cycle with rdata=32'h0050_0093, pc_write=1 -> next cycle ifid_write=1, pc_out=0, inst=32'h0050_0093; following cycle im_addr=4.
REQ-035 Stall: in HOLD with buf_pc=8, pc_write=0 for 3 cycles -> ifid_write=0, im_req=0, pc_out=8 steady; pc_write=1 -> one write, then im_addr=12.
REQ-036 Redirect with redirect_pc=32'h0000_0103 in HOLD, pc_write=0 -> same cycle ifid_write=1, inst=32'h0000_0013, pc_out=32'h100; next cycle im_addr=32'h100.
REQ-037 Redirect to 32'h200 while request to 32'h40 is pending; ack arrives 3 cycles later with rdata=32'hDEAD_BEEF -> im_addr stays 32'h40, data never reaches inst, then im_addr=32'h200.
REQ-038 Second redirect to 32'h300 during DROP, then redirect and ack in the same cycle -> after the drop, the fetch goes to the latest target only.
REQ-039 Wrap-around: buf_pc=32'hFFFF_FFFC written -> next im_addr=32'h0. Also, asserting rst mid-request -> im_req=0 at once, and the restart is at RESET_PC.
